// File: rtl/food_rand_gen.sv
`default_nettype none
// ============================================================================
// Module   : food_rand_gen
// Purpose  : Draws a random in-grid food cell that avoids the snake head,
//            falling back to a deterministic cell after RETRY_MAX rejections.
//            Optional macro RAND_START_AUTO_EN lets game_start trigger a draw.
// Revision : 1.0 - initial release
// ============================================================================
module food_rand_gen #(
    parameter logic [15:0] SEED       = 16'hACE1,
    parameter int          CELL_COUNT = 400,
    parameter int          RETRY_MAX  = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req,
    input  logic       game_start,
    input  logic [8:0] head_cell,
    output logic [8:0] rand_num,
    output logic       rand_drive,
    output logic       busy,
    output logic       fallback_used
);

    // An all-zero seed would lock the LFSR, so it is promoted to 1.
    localparam logic [15:0] c_seed = (SEED == 16'h0000) ? 16'h0001 : SEED;

    localparam int              c_rw         = (RETRY_MAX > 1) ? $clog2(RETRY_MAX) : 1;
    localparam logic [c_rw-1:0] c_retry_last = c_rw'(RETRY_MAX - 1);
    localparam logic [9:0]      c_cells      = 10'(CELL_COUNT);
    localparam logic [9:0]      c_half       = 10'(CELL_COUNT / 2);

    localparam logic [1:0] c_idle  = 2'd0;
    localparam logic [1:0] c_draw  = 2'd1;
    localparam logic [1:0] c_check = 2'd2;

    logic [15:0]     r_lfsr;
    logic [1:0]      r_state;
    logic [c_rw-1:0] r_retry;
    logic [8:0]      r_cand;
    logic [8:0]      r_rand_num;
    logic            r_rand_drive;
    logic            r_busy;
    logic            r_fallback_used;

    logic            w_lfsr_fb;
    logic            w_start;
    logic            w_cand_ok;
    logic [9:0]      w_fb_sum;
    logic [8:0]      w_fb_cell;

    assign w_lfsr_fb = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];

`ifdef RAND_START_AUTO_EN
    assign w_start = req | game_start;
`else
    logic w_unused_game_start;
    assign w_unused_game_start = game_start;
    assign w_start             = req;
`endif

    assign w_cand_ok = ({1'b0, r_cand} < c_cells) && (r_cand != head_cell);

    // Single conditional subtract; the result always fits in 9 bits.
    assign w_fb_sum  = {1'b0, head_cell} + c_half;
    assign w_fb_cell = 9'((w_fb_sum >= c_cells) ? (w_fb_sum - c_cells) : w_fb_sum);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lfsr          <= c_seed;
            r_state         <= c_idle;
            r_retry         <= '0;
            r_cand          <= '0;
            r_rand_num      <= '0;
            r_rand_drive    <= 1'b0;
            r_busy          <= 1'b0;
            r_fallback_used <= 1'b0;
        end else begin
            r_lfsr       <= {r_lfsr[14:0], w_lfsr_fb};
            r_rand_drive <= 1'b0;
            case (r_state)
                c_idle: begin
                    if (w_start) begin
                        r_state <= c_draw;
                        r_busy  <= 1'b1;
                        r_retry <= '0;
                    end
                end
                c_draw: begin
                    r_cand  <= r_lfsr[8:0];
                    r_state <= c_check;
                end
                c_check: begin
                    if (w_cand_ok) begin
                        r_rand_num      <= r_cand;
                        r_rand_drive    <= 1'b1;
                        r_fallback_used <= 1'b0;
                        r_busy          <= 1'b0;
                        r_state         <= c_idle;
                    end else if (r_retry == c_retry_last) begin
                        r_rand_num      <= w_fb_cell;
                        r_rand_drive    <= 1'b1;
                        r_fallback_used <= 1'b1;
                        r_busy          <= 1'b0;
                        r_state         <= c_idle;
                    end else begin
                        r_retry <= r_retry + c_rw'(1);
                        r_state <= c_draw;
                    end
                end
                default: begin
                    r_state <= c_idle;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign rand_num      = r_rand_num;
    assign rand_drive    = r_rand_drive;
    assign busy          = r_busy;
    assign fallback_used = r_fallback_used;

endmodule
`default_nettype wire
